i2c_slave_regfile: RTL and testbench
====================================

Name: i2c_slave_regfile

Overview:
- Synchronous, oversampled I2C target that sits on the bus directly downstream of the team's I2C master and consumes the transactions it generates.
- Decodes START/STOP, matches a 7-bit address, and acknowledges.
- Byte 1 of a write is a register pointer; following bytes write a small register bank. Reads return register contents with pointer auto-increment.
- Register bank outputs drive downstream control logic.

Parameters:
- SLAVE_ADDR, 7'b1010101, 7-bit bus address this target answers to.
- REG_COUNT, 4, number of 8-bit registers (power of two, 2..16).
- PTR_W, 2, pointer width = log2(REG_COUNT).

Ports:
- clk  input  1  system clock; must run ≥8x the SCL rate.
- rst  input  1  asynchronous, active-high reset.
- scl_in  input  1  raw SCL from the pad (asynchronous).
- sda_in  input  1  raw SDA from the pad (asynchronous).
- sda_oe  output  1  1 = pull SDA low; 0 = release SDA (high-Z).
- regs_flat  output  8*REG_COUNT  register bank; reg i occupies bits [8i+7:8i].
- wr_strobe  output  1  one-clk pulse when a register is written.
- wr_index  output  PTR_W  index written; valid with wr_strobe.
- busy  output  1  high from an address-matched START until STOP or NACK exit.

Behaviour:
- Reset values: sda_oe=0, all regs=8'h00, wr_strobe=0, wr_index=0, busy=0, ptr=0, state=IDLE. Reset mid-transfer aborts immediately and releases SDA.
- Input conditioning: 2-flop synchronizer on scl_in and sda_in, plus a previous-value register on each. Events are scl_rise, scl_fall, start (sda falls while scl high), stop (sda rises while scl high). Event latency is 3 clk after the pin change.
- Bit sampling: on scl_rise only. Output changes: on scl_fall only.
- START in any state: go to ADDR, clear bit counter, release sda_oe. This covers repeated START. Pointer is retained.
- STOP in any state: go to IDLE, release sda_oe, busy=0.
- ADDR: shift 8 bits MSB first.
  - Upper 7 bits == SLAVE_ADDR: go to ACK_ADDR, busy=1.
  - Otherwise: go to IDLE with no ACK.
- ACK_ADDR: assert sda_oe on the scl_fall after bit 8, release on the next scl_fall.
  - R/W=0: go to PTR.
  - R/W=1: go to RDATA, load shift register with reg[ptr], drive its MSB at the release edge.
- PTR: shift 8 bits. ptr <= byte[PTR_W-1:0]; upper bits are ignored. ACK as above, then go to WDATA.
- WDATA: shift 8 bits.
  - At the 8th scl_rise: reg[ptr] <= byte, wr_strobe=1 for exactly one clk, wr_index=ptr, then ptr <= ptr+1 (wraps modulo REG_COUNT).
  - ACK, then return to WDATA.
- RDATA:
  - Drive bits MSB first. sda_oe = ~bit, changed on scl_fall.
  - After bit 8, release SDA and sample the controller's ACK at the 9th scl_rise.
  - ACK (0): ptr++ (wrap), reload shift register with the new reg[ptr], continue.
  - NACK (1): go to WAIT_STOP (SDA released; only START/STOP are honoured), ptr++.
- sda_oe never changes while SCL is high, except on reset, START, or STOP.
- A register written in the same clk as a read load: the read load sees the old value.

Test Plan:
- Write 0xAA, ptr 0x01, data 0x3C, 0x7E, STOP -> ACK on all 4 bytes; reg1=0x3C, reg2=0x7E; two wr_strobe pulses with wr_index 1 then 2; busy=0 after STOP.
- Address 0x54 write -> no ACK (SDA high at 9th clock); regs unchanged; busy stays 0.
- Set ptr=3, repeated START, read 0xAB, controller ACKs twice then NACKs -> returns reg3, reg0, reg1 (wrap); SDA released after NACK.
- Write with ptr 0x03, data 0x11, 0x22 -> reg3=0x11, reg0=0x22 (pointer wrap).
- Assert rst while the target drives ACK low -> sda_oe=0 within the same cycle; regs cleared; next transaction is accepted normally.
- STOP mid-byte during WDATA after 4 bits -> no register write, no wr_strobe, state IDLE.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// Oversampled I2C target: 7-bit address match, pointer byte, then an auto-incrementing 8-bit register bank.
// Latency: bus events take effect 3 clk after the pin change; wr_strobe follows the 8th data rise by 1 clk.
// Backpressure: none; the target never stretches SCL, and a controller NACK on a read parks it until START/STOP.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1010101,
    parameter int         REG_COUNT  = 4,
    parameter int         PTR_W      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scl_in,
    input  logic                   sda_in,
    output logic                   sda_oe,
    output logic [8*REG_COUNT-1:0] regs_flat,
    output logic                   wr_strobe,
    output logic [PTR_W-1:0]       wr_index,
    output logic                   busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK,
        ST_PTR,
        ST_WDATA,
        ST_RDATA,
        ST_RACK,
        ST_WAIT_STOP
    } state_t;

    state_t                     state_q, state_d;
    state_t                     nxt_q, nxt_d;
    logic [2:0]                 scl_sh_q, scl_sh_d;
    logic [2:0]                 sda_sh_q, sda_sh_d;
    logic [2:0]                 bit_cnt_q, bit_cnt_d;
    logic [7:0]                 shreg_q, shreg_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic [REG_COUNT-1:0][7:0]  regs_q, regs_d;
    logic                       sda_oe_q, sda_oe_d;
    logic                       busy_q, busy_d;
    logic                       wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0]           wr_index_q, wr_index_d;
    logic                       phase_q, phase_d;

    logic                       scl_rise, scl_fall, start_ev, stop_ev, sda_bit;
    logic [7:0]                 rx_byte;
    logic [PTR_W-1:0]           ptr_inc;

    // [0],[1] form the synchronizer; [2] is the previous synchronized value.
    assign sda_bit  = sda_sh_q[1];
    assign scl_rise = scl_sh_q[1] & ~scl_sh_q[2];
    assign scl_fall = ~scl_sh_q[1] & scl_sh_q[2];
    assign start_ev = scl_sh_q[1] & scl_sh_q[2] & sda_sh_q[2] & ~sda_sh_q[1];
    assign stop_ev  = scl_sh_q[1] & scl_sh_q[2] & ~sda_sh_q[2] & sda_sh_q[1];
    assign rx_byte  = {shreg_q[6:0], sda_bit};
    assign ptr_inc  = ptr_q + PTR_W'(1);

    always_comb begin
        scl_sh_d    = {scl_sh_q[1:0], scl_in};
        sda_sh_d    = {sda_sh_q[1:0], sda_in};
        state_d     = state_q;
        nxt_d       = nxt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        ptr_d       = ptr_q;
        regs_d      = regs_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        phase_d     = phase_q;

        if (start_ev) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_ev) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_ACK;
                            phase_d = 1'b0;
                            nxt_d   = ST_WDATA;
                            case (state_q)
                                ST_ADDR: begin
                                    if (rx_byte[7:1] == SLAVE_ADDR) begin
                                        busy_d = 1'b1;
                                        nxt_d  = rx_byte[0] ? ST_RDATA : ST_PTR;
                                    end else begin
                                        state_d = ST_IDLE;
                                        busy_d  = 1'b0;
                                    end
                                end
                                ST_PTR: ptr_d = rx_byte[PTR_W-1:0];
                                default: begin
                                    regs_d[ptr_q] = rx_byte;
                                    wr_strobe_d   = 1'b1;
                                    wr_index_d    = ptr_q;
                                    ptr_d         = ptr_inc;
                                end
                            endcase
                        end
                    end
                end
                ST_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            state_d   = nxt_q;
                            bit_cnt_d = 3'd0;
                            if (nxt_q == ST_RDATA) begin
                                shreg_d  = regs_q[ptr_q];
                                sda_oe_d = ~regs_q[ptr_q][7];
                            end else begin
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    // The MSB went out on entry, so falls 1..7 carry bits 6..0 and fall 8 frees SDA.
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RACK;
                            phase_d  = 1'b0;
                        end else begin
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            sda_oe_d  = ~shreg_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_RACK: begin
                    if (!phase_q && scl_rise) begin
                        ptr_d = ptr_inc;
                        if (!sda_bit) begin
                            shreg_d = regs_q[ptr_inc];
                            phase_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end else if (phase_q && scl_fall) begin
                        sda_oe_d  = ~shreg_q[7];
                        bit_cnt_d = 3'd0;
                        state_d   = ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            nxt_q       <= ST_IDLE;
            scl_sh_q    <= 3'b111;
            sda_sh_q    <= 3'b111;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            ptr_q       <= '0;
            regs_q      <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            nxt_q       <= nxt_d;
            scl_sh_q    <= scl_sh_d;
            sda_sh_q    <= sda_sh_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            ptr_q       <= ptr_d;
            regs_q      <= regs_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
            phase_q     <= phase_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign regs_flat = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: a bit-banged I2C controller drives the target through writes, reads, wrap, aborts and reset.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_drv = 1'b1;
    logic        sda_drv = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic [31:0] regs_flat;
    logic        wr_strobe;
    logic [1:0]  wr_index;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int strobe_cnt = 0;
    int idx_log[$];

    assign sda_line = sda_drv & ~sda_oe;

    i2c_slave_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_drv),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt++;
            idx_log.push_back(int'(wr_index));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wq();
        repeat (8) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; wq();
        scl_drv = 1'b1; wq();
        sda_drv = 1'b0; wq();
        scl_drv = 1'b0; wq();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wq();
        scl_drv = 1'b1; wq();
        sda_drv = 1'b1; wq();
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; wq();
        scl_drv = 1'b1; wq(); wq();
        scl_drv = 1'b0; wq();
    endtask

    task automatic recv_bit(output logic b);
        sda_drv = 1'b1; wq();
        scl_drv = 1'b1; wq();
        b = sda_line; wq();
        scl_drv = 1'b0; wq();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(ack);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        n_vec++; if (regs_flat !== 32'h0) begin n_err++; $display("FAIL reset_regs got %h want 00000000", regs_flat); end
        n_vec++; if (wr_strobe !== 1'b0) begin n_err++; $display("FAIL reset_wr_strobe got %b want 0", wr_strobe); end
        n_vec++; if (wr_index !== 2'd0) begin n_err++; $display("FAIL reset_wr_index got %0d want 0", wr_index); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        logic ack;
        int   s0;
        logic [7:0] data [3] = '{8'h01, 8'h3C, 8'h7E};
        s0 = strobe_cnt;
        bus_start();
        send_byte(8'hAA, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL write_addr_ack got %b want 0", ack); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL write_busy got %b want 1", busy); end
        for (int i = 0; i < 3; i++) begin
            send_byte(data[i], ack);
            n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL write_byte%0d_ack got %b want 0", i, ack); end
        end
        bus_stop();
        wq();
        n_vec++; if (regs_flat !== 32'h007E3C00) begin n_err++; $display("FAIL write_regs got %h want 007e3c00", regs_flat); end
        n_vec++; if (strobe_cnt - s0 !== 2) begin n_err++; $display("FAIL write_strobes got %0d want 2", strobe_cnt - s0); end
        n_vec++; if (idx_log.size() < 2 || idx_log[0] !== 1 || idx_log[1] !== 2) begin
            n_err++; $display("FAIL write_index got %p want 1,2", idx_log);
        end
        idx_log.delete();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL write_busy_after_stop got %b want 0", busy); end
    endtask

    task automatic test_bad_addr();
        logic ack;
        int   s0;
        s0 = strobe_cnt;
        bus_start();
        send_byte(8'hA8, ack);
        n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL badaddr_ack got %b want 1", ack); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL badaddr_busy got %b want 0", busy); end
        send_byte(8'h00, ack);
        send_byte(8'hFF, ack);
        bus_stop();
        wq();
        n_vec++; if (regs_flat !== 32'h007E3C00) begin n_err++; $display("FAIL badaddr_regs got %h want 007e3c00", regs_flat); end
        n_vec++; if (strobe_cnt !== s0) begin n_err++; $display("FAIL badaddr_strobes got %0d want %0d", strobe_cnt, s0); end
    endtask

    task automatic test_ptr_wrap();
        logic ack;
        int   s0;
        logic [7:0] bytes [4] = '{8'hAA, 8'h03, 8'h11, 8'h22};
        s0 = strobe_cnt;
        bus_start();
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i], ack);
            n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL wrap_byte%0d_ack got %b want 0", i, ack); end
        end
        bus_stop();
        wq();
        n_vec++; if (regs_flat !== 32'h117E3C22) begin n_err++; $display("FAIL wrap_regs got %h want 117e3c22", regs_flat); end
        n_vec++; if (strobe_cnt - s0 !== 2) begin n_err++; $display("FAIL wrap_strobes got %0d want 2", strobe_cnt - s0); end
        n_vec++; if (idx_log.size() < 2 || idx_log[0] !== 3 || idx_log[1] !== 0) begin
            n_err++; $display("FAIL wrap_index got %p want 3,0", idx_log);
        end
        idx_log.delete();
    endtask

    task automatic test_read_wrap();
        logic       ack;
        logic [7:0] d;
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h3C};
        bus_start();
        send_byte(8'hAA, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL read_waddr_ack got %b want 0", ack); end
        send_byte(8'h03, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL read_ptr_ack got %b want 0", ack); end
        bus_start();
        send_byte(8'hAB, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL read_raddr_ack got %b want 0", ack); end
        for (int i = 0; i < 3; i++) begin
            recv_byte(d, (i == 2) ? 1'b1 : 1'b0);
            n_vec++; if (d !== exp_d[i]) begin n_err++; $display("FAIL read_data%0d got %h want %h", i, d, exp_d[i]); end
        end
        wq();
        n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL read_release_after_nack got %b want 0", sda_oe); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL read_busy_after_nack got %b want 0", busy); end
        bus_stop();
        wq();
        n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL read_release_after_stop got %b want 0", sda_oe); end
    endtask

    task automatic test_stop_mid_byte();
        logic ack;
        int   s0;
        s0 = strobe_cnt;
        bus_start();
        send_byte(8'hAA, ack);
        send_byte(8'h00, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL stopmid_ptr_ack got %b want 0", ack); end
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bus_stop();
        wq();
        n_vec++; if (regs_flat !== 32'h117E3C22) begin n_err++; $display("FAIL stopmid_regs got %h want 117e3c22", regs_flat); end
        n_vec++; if (strobe_cnt !== s0) begin n_err++; $display("FAIL stopmid_strobes got %0d want %0d", strobe_cnt, s0); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stopmid_busy got %b want 0", busy); end
        n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL stopmid_sda_oe got %b want 0", sda_oe); end
    endtask

    task automatic test_reset_during_ack();
        logic ack;
        logic [7:0] a = 8'hAA;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(a[i]);
        n_vec++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL rstack_driving got %b want 1", sda_oe); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rstack_release got %b want 0", sda_oe); end
        n_vec++; if (regs_flat !== 32'h0) begin n_err++; $display("FAIL rstack_regs got %h want 00000000", regs_flat); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstack_busy got %b want 0", busy); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wq();
        bus_stop();
        wq();
        idx_log.delete();
        bus_start();
        send_byte(8'hAA, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rstack_next_addr_ack got %b want 0", ack); end
        send_byte(8'h02, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rstack_next_ptr_ack got %b want 0", ack); end
        send_byte(8'h5A, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rstack_next_data_ack got %b want 0", ack); end
        bus_stop();
        wq();
        n_vec++; if (regs_flat !== 32'h005A0000) begin n_err++; $display("FAIL rstack_next_regs got %h want 005a0000", regs_flat); end
        n_vec++; if (idx_log.size() != 1 || idx_log[0] !== 2) begin
            n_err++; $display("FAIL rstack_next_index got %p want 2", idx_log);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_bad_addr();
        test_ptr_wrap();
        test_read_wrap();
        test_stop_mid_byte();
        test_reset_during_ack();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
